// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the program-counter stage: address width, reset
// PC default, FSM state encoding and the next-PC source selector.
package pc_pkg;

    localparam int unsigned PC_WIDTH = 16;

    localparam logic [PC_WIDTH-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef logic [PC_WIDTH-1:0] pc_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } pc_state_t;

    // Which source the next PC comes from on a fire cycle.
    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_HOLD   = 2'd3
    } pc_sel_t;

    // A jump or taken branch loads a new target and costs a flush bubble.
    function automatic logic is_redirect(input pc_sel_t sel);
        return (sel == SEL_JUMP) || (sel == SEL_BRANCH);
    endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// Fetch-address handshake between the PC stage (master) and fetch (slave).
import pc_pkg::*;

interface pc_branch_unit_if;
    logic fetch_valid_o;
    logic fetch_ready_i;
    pc_t  pc_o;

    modport master (output fetch_valid_o, output pc_o, input  fetch_ready_i);
    modport slave  (input  fetch_valid_o, input  pc_o, output fetch_ready_i);
endinterface

// File: rtl/pc_branch_unit_pc_target_mux.sv
// Combinational next-PC selection: priority encode HALT > JR > taken
// branch > sequential, plus the modulo-2^16 adders.
import pc_pkg::*;

module pc_target_mux #(
    parameter pc_t STEP = 16'd1
) (
    input  pc_t     pc_i,
    input  pc_t     offset_i,
    input  pc_t     jr_target_i,
    input  logic    halt_req_i,
    input  logic    jr_req_i,
    input  logic    br_req_i,
    input  logic    br_cond_i,
    output pc_sel_t sel_o,
    output pc_t     next_pc_o
);

    // Priority encode the request and form the candidate next PC.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        sel_o     = SEL_SEQ;
        next_pc_o = pc_i + STEP;
        if (halt_req_i) begin
            sel_o     = SEL_HOLD;
            next_pc_o = pc_i;
        end else if (jr_req_i) begin
            sel_o     = SEL_JUMP;
            next_pc_o = jr_target_i;
        end else if (br_req_i && br_cond_i) begin
            sel_o     = SEL_BRANCH;
            next_pc_o = pc_i + offset_i;
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program-counter stage: owns the PC register and the BOOT/RUN/FLUSH/HALT
// FSM, drives the fetch address over a valid/ready handshake and inserts
// one flush bubble after every jump or taken branch.
// Optional feature macro: PC_BRANCH_UNIT_BRCNT_EN adds branch_cnt_o, a
// saturating count of taken branches and jumps.
import pc_pkg::*;

module pc_branch_unit #(
    parameter pc_t RESET_PC = RESET_PC_DEFAULT,
    parameter pc_t STEP     = 16'd1
) (
    input  logic                     clk,
    input  logic                     rst,
    pc_branch_unit_if.master         fetch,
    input  pc_t                      offset_i,
    input  logic                     br_req_i,
    input  logic                     br_cond_i,
    input  logic                     jr_req_i,
    input  pc_t                      jr_target_i,
    input  logic                     halt_req_i,
    input  logic                     resume_i,
`ifdef PC_BRANCH_UNIT_BRCNT_EN
    output logic [15:0]              branch_cnt_o,
`endif
    output logic                     redirect_o,
    output logic                     halted_o
);

    pc_state_t state_q;
    pc_t       pc_q;
    pc_t       pc_d;
    pc_sel_t   sel_d;
    logic      valid_q;
    logic      redirect_q;
    logic      halted_q;
    logic      fire;

    // valid_q is only ever high in RUN, so a fire is always a RUN cycle.
    assign fire = valid_q && fetch.fetch_ready_i;

    pc_target_mux #(.STEP(STEP)) u_target_mux (
        .pc_i        (pc_q),
        .offset_i    (offset_i),
        .jr_target_i (jr_target_i),
        .halt_req_i  (halt_req_i),
        .jr_req_i    (jr_req_i),
        .br_req_i    (br_req_i),
        .br_cond_i   (br_cond_i),
        .sel_o       (sel_d),
        .next_pc_o   (pc_d)
    );

    // FSM with registered PC and registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            redirect_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            redirect_q <= 1'b0;
            unique case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: begin
                    if (fire) begin
                        unique case (sel_d)
                            SEL_HOLD: begin
                                state_q  <= HALT;
                                valid_q  <= 1'b0;
                                halted_q <= 1'b1;
                            end
                            SEL_JUMP, SEL_BRANCH: begin
                                pc_q       <= pc_d;
                                state_q    <= FLUSH;
                                valid_q    <= 1'b0;
                                redirect_q <= 1'b1;
                            end
                            default: pc_q <= pc_d;
                        endcase
                    end
                end
                FLUSH: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                HALT: begin
                    if (resume_i) begin
                        state_q  <= RUN;
                        valid_q  <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign fetch.pc_o          = pc_q;
    assign fetch.fetch_valid_o = valid_q;
    assign redirect_o          = redirect_q;
    assign halted_o            = halted_q;

`ifdef PC_BRANCH_UNIT_BRCNT_EN
    logic [15:0] branch_cnt_q;

    // Count redirects on the same edge that loads the new target; saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q <= 16'h0000;
        end else if (fire && is_redirect(sel_d) && (branch_cnt_q != 16'hFFFF)) begin
            branch_cnt_q <= branch_cnt_q + 16'd1;
        end
    end

    assign branch_cnt_o = branch_cnt_q;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: reset/boot, stalls, branches, jumps,
// priority, halt/resume, flush bubble, wrap and (optionally) branch count.
import pc_pkg::*;

module tb_pc_branch_unit;

    logic clk = 1'b0;
    logic rst;
    pc_t  offset_i;
    logic br_req_i, br_cond_i, jr_req_i, halt_req_i, resume_i;
    pc_t  jr_target_i;
    logic redirect_o, halted_o;
`ifdef PC_BRANCH_UNIT_BRCNT_EN
    logic [15:0] branch_cnt_o;
`endif

    int n_compared = 0;
    int n_mismatched = 0;

    pc_branch_unit_if fetch_if ();

    always #5 clk = ~clk;

    pc_branch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .fetch       (fetch_if.master),
        .offset_i    (offset_i),
        .br_req_i    (br_req_i),
        .br_cond_i   (br_cond_i),
        .jr_req_i    (jr_req_i),
        .jr_target_i (jr_target_i),
        .halt_req_i  (halt_req_i),
        .resume_i    (resume_i),
`ifdef PC_BRANCH_UNIT_BRCNT_EN
        .branch_cnt_o(branch_cnt_o),
`endif
        .redirect_o  (redirect_o),
        .halted_o    (halted_o)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input pc_t pc, input logic valid,
                             input logic redir, input logic halt);
        check({tag, ".pc"},       32'(fetch_if.pc_o),          32'(pc));
        check({tag, ".valid"},    32'(fetch_if.fetch_valid_o), 32'(valid));
        check({tag, ".redirect"}, 32'(redirect_o),             32'(redir));
        check({tag, ".halted"},   32'(halted_o),               32'(halt));
    endtask

    task automatic clear_req();
        br_req_i = 1'b0; br_cond_i = 1'b0; jr_req_i = 1'b0;
        halt_req_i = 1'b0; resume_i = 1'b0;
    endtask

    // Jump to target and let the flush bubble pass; leaves ready=1, PC=target, RUN.
    task automatic jump_to(input pc_t target);
        jr_req_i = 1'b1; jr_target_i = target; fetch_if.fetch_ready_i = 1'b1;
        step();
        jr_req_i = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        fetch_if.fetch_ready_i = 1'b0;
        offset_i = '0; jr_target_i = '0;
        clear_req();

        // Reset state.
        step();
        check_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        check_out("boot", 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        check_out("run_after_boot", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Sequential with stall pattern 1,0,1: pc 0,1,1,2.
        fetch_if.fetch_ready_i = 1'b1; step();
        check("seq1.pc", 32'(fetch_if.pc_o), 32'h1);
        fetch_if.fetch_ready_i = 1'b0; br_req_i = 1'b1; br_cond_i = 1'b1; offset_i = 16'h0100;
        step();
        check("stall.pc", 32'(fetch_if.pc_o), 32'h1);
        check("stall.redirect", 32'(redirect_o), 32'h0);
        clear_req();
        fetch_if.fetch_ready_i = 1'b1; step();
        check("seq2.pc", 32'(fetch_if.pc_o), 32'h2);

        // Jump to 0x0010 with flush bubble.
        jr_req_i = 1'b1; jr_target_i = 16'h0010; step();
        jr_req_i = 1'b0;
        check_out("jr_flush", 16'h0010, 1'b0, 1'b1, 1'b0);
        step();
        check_out("jr_after", 16'h0010, 1'b1, 1'b0, 1'b0);
`ifdef PC_BRANCH_UNIT_BRCNT_EN
        check("cnt1", 32'(branch_cnt_o), 32'd1);
`endif

        // Backward taken branch 0x10 + 0xFFF8 = 0x0008.
        br_req_i = 1'b1; br_cond_i = 1'b1; offset_i = 16'hFFF8; step();
        clear_req();
        check_out("bwd_flush", 16'h0008, 1'b0, 1'b1, 1'b0);
        step();
        check_out("bwd_after", 16'h0008, 1'b1, 1'b0, 1'b0);

        // Not-taken branch from 0x0010 is sequential.
        jump_to(16'h0010);
`ifdef PC_BRANCH_UNIT_BRCNT_EN
        check("cnt3", 32'(branch_cnt_o), 32'd3);
`endif
        br_req_i = 1'b1; br_cond_i = 1'b0; offset_i = 16'hFFF8; step();
        clear_req();
        check_out("not_taken", 16'h0011, 1'b1, 1'b0, 1'b0);

        // Priority: halt beats jump and taken branch.
        halt_req_i = 1'b1; jr_req_i = 1'b1; jr_target_i = 16'h1234;
        br_req_i = 1'b1; br_cond_i = 1'b1; step();
        clear_req();
        check_out("halt_prio", 16'h0011, 1'b0, 1'b0, 1'b1);
        jr_req_i = 1'b1; step();
        clear_req();
        check_out("halt_ignore", 16'h0011, 1'b0, 1'b0, 1'b1);
        resume_i = 1'b1; step();
        resume_i = 1'b0;
        check_out("resume", 16'h0011, 1'b1, 1'b0, 1'b0);
`ifdef PC_BRANCH_UNIT_BRCNT_EN
        check("cnt_halt", 32'(branch_cnt_o), 32'd3);
`endif

        // resume_i in RUN has no effect.
        fetch_if.fetch_ready_i = 1'b0; resume_i = 1'b1; step();
        resume_i = 1'b0;
        check_out("resume_in_run", 16'h0011, 1'b1, 1'b0, 1'b0);

        // Requests during FLUSH are ignored; then 0x0002 + 0xFFFC = 0xFFFE.
        fetch_if.fetch_ready_i = 1'b1;
        jr_req_i = 1'b1; jr_target_i = 16'h0002; step();
        jr_req_i = 1'b0; br_req_i = 1'b1; br_cond_i = 1'b1; offset_i = 16'hFFFC;
        step();
        check_out("flush_ignore", 16'h0002, 1'b1, 1'b0, 1'b0);
        step();
        clear_req();
        check_out("neg_offset", 16'hFFFE, 1'b0, 1'b1, 1'b0);
        step();

        // Wrap 0xFFFF + 1 = 0x0000.
        jump_to(16'hFFFF);
        check("wrap_pre.pc", 32'(fetch_if.pc_o), 32'hFFFF);
        step();
        check_out("wrap", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-run from pc 0x0040 takes effect immediately.
        jump_to(16'h0040);
`ifdef PC_BRANCH_UNIT_BRCNT_EN
        check("cnt7", 32'(branch_cnt_o), 32'd7);
`endif
        check("pre_rst.pc", 32'(fetch_if.pc_o), 32'h0040);
        #2 rst = 1'b1;
        #1;
        check_out("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
`ifdef PC_BRANCH_UNIT_BRCNT_EN
        check("cnt_rst", 32'(branch_cnt_o), 32'd0);
`endif
        step();
        rst = 1'b0;
        check_out("reboot", 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        check_out("rerun", 16'h0000, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter stage directly downstream of the 12-to-16-bit immediate sign extender.
- Consumes the sign-extended 16-bit branch offset and computes PC-relative branch targets.
- Also handles register-indirect jumps and halt.
- Drives the fetch address with a valid/ready handshake and inserts one flush bubble after every redirect.

Parameters:
- PC_WIDTH, 16, width of PC and of every address/offset port.
- RESET_PC, 16'h0000, PC value loaded on reset.
- STEP, 1, sequential increment; the machine is word-addressed.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fetch_ready_i  in  1  fetch side accepts pc_o this cycle.
- fetch_valid_o  out  1  pc_o is a valid fetch address.
- pc_o  out  PC_WIDTH  current fetch address.
- offset_i  in  PC_WIDTH  sign-extended branch offset from the sign extender.
- br_req_i  in  1  current instruction is a conditional branch.
- br_cond_i  in  1  branch condition (accumulator flag) is true.
- jr_req_i  in  1  current instruction is a register jump.
- jr_target_i  in  PC_WIDTH  absolute jump target.
- halt_req_i  in  1  current instruction is HALT.
- resume_i  in  1  leave HALT state.
- redirect_o  out  1  one-cycle pulse on a taken branch or jump.
- halted_o  out  1  block is in HALT state.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - state=BOOT, pc_o=RESET_PC.
  - fetch_valid_o=0, redirect_o=0, halted_o=0.
  - Reset asserted mid-operation aborts any flush or halt immediately.
- States: BOOT, RUN, FLUSH, HALT.
- BOOT: lasts exactly one cycle after reset deassertion, with fetch_valid_o=0; then goes to RUN.
- RUN:
  - fetch_valid_o=1.
  - A transfer fires when fetch_valid_o and fetch_ready_i are both 1.
  - Request inputs are sampled only on a fire cycle. With fetch_ready_i=0, pc_o holds and requests are ignored.
- Priority on a fire cycle, highest first:
  1. halt_req_i: pc_o unchanged; go to HALT.
  2. jr_req_i: pc_o <= jr_target_i; redirect_o=1 next cycle; go to FLUSH.
  3. br_req_i & br_cond_i: pc_o <= pc_o + offset_i (mod 2^PC_WIDTH); redirect_o=1 next cycle; go to FLUSH.
  4. Otherwise: pc_o <= pc_o + STEP (mod 2^PC_WIDTH); stay in RUN.
- br_req_i with br_cond_i=0 is treated as sequential; redirect_o stays 0.
- Arithmetic: unsigned modulo-2^16 addition, so a negative offset wraps correctly.
  - 16'hFFFF + STEP gives 16'h0000.
  - 16'h0002 + 16'hFFFC gives 16'hFFFE.
- FLUSH:
  - Exactly one cycle with fetch_valid_o=0; all request inputs ignored; pc_o holds the new target.
  - Then return to RUN.
- redirect_o is high only in the FLUSH cycle (one-cycle pulse).
- HALT:
  - fetch_valid_o=0, halted_o=1, pc_o held; all requests ignored.
  - resume_i=1 returns to RUN next cycle with pc_o unchanged.
- resume_i outside HALT has no effect.
- Latency: pc_o reflects the decision one cycle after the fire edge.

Optional Feature:
- Macro: PC_BRANCH_UNIT_BRCNT_EN.
- With the macro defined:
  - Extra output port branch_cnt_o, 16 bits.
  - Counts taken branches and jumps; saturates at 16'hFFFF.
  - Reset value 0.
  - Increments in the same edge that loads a redirect target.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pc_pkg holds:
  - PC_WIDTH constant.
  - pc_state_t enum (BOOT, RUN, FLUSH, HALT).
  - RESET_PC default.
- One natural sub-module: pc_target_mux.
  - Combinational next-PC selection: priority encode plus adder.
  - Keeps pc_branch_unit as the FSM and register owner.

Test Plan:
- Reset/boot: assert rst mid-run with pc_o=16'h0040 -> pc_o=16'h0000 immediately and fetch_valid_o=0. After release: one BOOT cycle, then fetch_valid_o=1.
- Sequential with stalls: fetch_ready_i pattern 1,0,1 from pc 0 -> pc_o goes 0,1,1,2.
- Backward branch: at pc 16'h0010, br_req_i=1, br_cond_i=1, offset_i=16'hFFF8 -> pc_o=16'h0008, redirect_o pulses 1 cycle, fetch_valid_o=0 for 1 cycle.
- Not-taken branch: same stimulus with br_cond_i=0 -> pc_o=16'h0011, no redirect_o pulse.
- Priority: halt_req_i, jr_req_i (target 16'h1234) and a taken branch all in one fire cycle -> HALT entered, pc_o unchanged, no redirect_o. Then resume_i -> RUN at the same pc.
- Wrap: pc 16'hFFFF sequential -> 16'h0000. With the macro defined, three taken branches -> branch_cnt_o=3.
